// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the fall-through FIFO and serialises each byte as
// a UART frame (start, 8 data LSB first, optional parity, 1 or 2 stop).
// Ports: clk, rst_n (async active-low); enable gates new frames;
//   fifo_empty/fifo_data observe the FIFO head, fifo_rd pops it;
//   tx serial line (idle 1), busy during a frame, frame_done on the
//   last stop cycle.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY_ODD != 0);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    idx, idx_nx;
    logic          stop_cnt, stop_nx;
    logic [7:0]    shift, shift_nx;
    logic          par, par_nx;
    logic          tx_nx, busy_nx, done_nx;
    logic          bit_end, last_stop, load_pt, pop;

    assign bit_end   = (cnt == LAST);
    assign last_stop = (stop_cnt == STOP_LAST);
    assign load_pt   = (state == IDLE) ||
                       (state == STOP && bit_end && last_stop);
    assign pop       = enable && !fifo_empty;
    // Gated by rst_n so nothing is popped while held in reset.
    assign fifo_rd   = rst_n && load_pt && pop;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        stop_nx  = stop_cnt;
        shift_nx = shift;
        par_nx   = par;

        if (state != IDLE) begin
            cnt_nx = bit_end ? '0 : cnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
            end
            START: begin
                if (bit_end) begin
                    state_nx = DATA;
                    idx_nx   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nx = {1'b0, shift[7:1]};
                    idx_nx   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nx = HAS_PAR ? PARITY : STOP;
                        stop_nx  = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nx = STOP;
                    stop_nx  = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        state_nx = IDLE;
                    end else begin
                        stop_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A pop overrides the above: load the byte and start a frame,
        // which gives back-to-back frames with no idle gap.
        if (fifo_rd) begin
            state_nx = START;
            cnt_nx   = '0;
            idx_nx   = '0;
            stop_nx  = 1'b0;
            shift_nx = fifo_data;
            par_nx   = (^fifo_data) ^ ODD;
        end

        // Outputs are registered from the next state so they line up
        // with the state they describe.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            PARITY:  tx_nx = par_nx;
            default: tx_nx = 1'b1;
        endcase
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == STOP) && (cnt_nx == LAST) &&
                  (stop_nx == STOP_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            stop_cnt   <= 1'b0;
            shift      <= '0;
            par        <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            stop_cnt   <= stop_nx;
            shift      <= shift_nx;
            par        <= par_nx;
            tx         <= tx_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
        end
    end

endmodule
